// File: rtl/dcp_run_ctrl_if.sv
// Handshake and status bundle between the debug command decoder and the
// CPU run/step controller. master = decoder/host side, slave = controller.
interface dcp_run_ctrl_if;
  logic [7:0]  sel_mode;
  logic        start;
  logic [31:0] bp_addr;
  logic        stop_req;
  logic        pc_chk;
  logic [31:0] pc;
  logic        clk_cpu;
  logic        busy;
  logic        finish;
  logic        hit;
  logic [31:0] cyc_cnt;

  modport master (
    output sel_mode, start, bp_addr, stop_req, pc_chk, pc,
    input  clk_cpu, busy, finish, hit, cyc_cnt
  );

  modport slave (
    input  sel_mode, start, bp_addr, stop_req, pc_chk, pc,
    output clk_cpu, busy, finish, hit, cyc_cnt
  );
endinterface

// File: rtl/dcp_run_ctrl.sv
// Run/step controller for the debug unit's CPU clock. Generates clk_cpu for
// single step (T), run to breakpoint (B) and free run (G), checks pc against
// the breakpoint at every CPU-cycle boundary and counts executed CPU cycles.
module dcp_run_ctrl #(
  parameter logic [7:0] CMD_T       = 8'h54,
  parameter logic [7:0] CMD_B       = 8'h42,
  parameter logic [7:0] CMD_G       = 8'h47,
  parameter int         HALF_PERIOD = 2
) (
  input logic           clk,
  input logic           rst,
  dcp_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);

  state_t      state, state_next;
  logic [7:0]  phase, phase_next;
  logic [7:0]  mode, mode_next;
  logic [31:0] bp, bp_next;
  logic        abort, abort_next;
  logic [31:0] cnt_next;
  logic        hit_next;
  logic        clk_cpu_next;
  logic        busy_next;
  logic        finish_next;
  logic        legal_cmd;
  logic        stop_seen;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // Next-state, latched-command and registered-output computation.
  always_comb begin
    state_next   = state;
    phase_next   = phase;
    mode_next    = mode;
    bp_next      = bp;
    abort_next   = abort;
    cnt_next     = bus.cyc_cnt;
    hit_next     = bus.hit;
    legal_cmd    = (bus.sel_mode == CMD_T) || (bus.sel_mode == CMD_B) ||
                   (bus.sel_mode == CMD_G);
    // A stop request seen during the pulse is remembered in abort and acted
    // on only at the cycle boundary, so clk_cpu pulses are never cut short.
    stop_seen    = abort || bus.stop_req;

    case (state)
      IDLE: begin
        if (bus.start && legal_cmd) begin
          state_next = HIGH;
          phase_next = 8'd0;
          mode_next  = bus.sel_mode;
          bp_next    = bus.bp_addr;
          cnt_next   = 32'd0;
          hit_next   = 1'b0;
          abort_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      HIGH: begin
        abort_next = stop_seen;
        if (phase == PHASE_LAST) begin
          state_next = LOW;
          phase_next = 8'd0;
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      LOW: begin
        abort_next = stop_seen;
        if (phase == PHASE_LAST) begin
          state_next = CHECK;
          phase_next = 8'd0;
          cnt_next   = sat_inc(bus.cyc_cnt);
        end else begin
          phase_next = phase + 8'd1;
        end
      end
      CHECK: begin
        if (mode == CMD_T) begin
          state_next = DONE;
        end else if ((mode == CMD_B) && bus.pc_chk && (bus.pc == bp)) begin
          // A breakpoint match takes priority over a simultaneous stop.
          state_next = DONE;
          hit_next   = 1'b1;
        end else if (stop_seen) begin
          state_next = DONE;
        end else begin
          state_next = HIGH;
        end
      end
      DONE: begin
        abort_next = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    clk_cpu_next = (state_next == HIGH);
    busy_next    = (state_next == HIGH) || (state_next == LOW) ||
                   (state_next == CHECK);
    finish_next  = (state_next == DONE);
  end

  // State, phase timer, latched command and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= 8'd0;
      mode        <= 8'd0;
      bp          <= 32'd0;
      abort       <= 1'b0;
      bus.clk_cpu <= 1'b0;
      bus.busy    <= 1'b0;
      bus.finish  <= 1'b0;
      bus.hit     <= 1'b0;
      bus.cyc_cnt <= 32'd0;
    end else begin
      state       <= state_next;
      phase       <= phase_next;
      mode        <= mode_next;
      bp          <= bp_next;
      abort       <= abort_next;
      bus.clk_cpu <= clk_cpu_next;
      bus.busy    <= busy_next;
      bus.finish  <= finish_next;
      bus.hit     <= hit_next;
      bus.cyc_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_dcp_run_ctrl.sv
// Self-checking bench for dcp_run_ctrl (HALF_PERIOD=2): table of command runs
// with a small CPU pc model, plus hand sequences for step latency, illegal
// and overlapping starts, and asynchronous reset mid-run.
module tb_dcp_run_ctrl;
  localparam logic [7:0] CMD_T = 8'h54;
  localparam logic [7:0] CMD_B = 8'h42;
  localparam logic [7:0] CMD_G = 8'h47;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  dcp_run_ctrl_if bus ();

  dcp_run_ctrl #(
    .CMD_T(CMD_T), .CMD_B(CMD_B), .CMD_G(CMD_G), .HALF_PERIOD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  mode;
    logic [31:0] bp;
    logic [31:0] pc0;
    int          wrap;       // pc returns to pc0 every wrap pulses (0 = never)
    logic        chk;
    int          stop_at;    // pulse number during which stop_req pulses (0 = none)
    int          restart_at; // pulse number during which start is re-pulsed (0 = none)
    int          exp_pulses;
    logic [31:0] exp_cyc;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one command and follow it to finish, modelling pc and stop/restart.
  task automatic run(input vec_t v);
    int   pulses;
    logic prev;
    logic done;
    @(negedge clk);
    bus.sel_mode = v.mode;
    bus.bp_addr  = v.bp;
    bus.pc_chk   = v.chk;
    bus.pc       = v.pc0;
    bus.stop_req = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    prev   = 1'b0;
    done   = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (bus.clk_cpu && !prev) begin
        pulses++;
        bus.pc = bus.pc + 32'd4;
        if ((v.wrap != 0) && (pulses % v.wrap == 0)) bus.pc = v.pc0;
        if (pulses == v.stop_at) bus.stop_req = 1'b1;
        if (pulses == v.restart_at) begin
          bus.sel_mode = CMD_T;
          bus.start    = 1'b1;
        end
      end else begin
        bus.stop_req = 1'b0;
        bus.start    = 1'b0;
        bus.sel_mode = v.mode;
      end
      prev = bus.clk_cpu;
      if (bus.finish) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({v.name, " finished"}, 32'(done), 32'd1);
    chk({v.name, " busy at finish"}, 32'(bus.busy), 32'd0);
    chk({v.name, " pulses"}, 32'(pulses), 32'(v.exp_pulses));
    chk({v.name, " cyc_cnt"}, bus.cyc_cnt, v.exp_cyc);
    chk({v.name, " hit"}, 32'(bus.hit), 32'(v.exp_hit));
    bus.stop_req = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
    chk({v.name, " finish one cycle"}, 32'(bus.finish), 32'd0);
  endtask

  // Cycle-exact single step: clk_cpu k+1..k+2, busy k+1..k+5, finish k+6.
  task automatic step_latency(input string tag);
    logic [6:0] exp_cpu;
    logic [6:0] exp_busy;
    logic [6:0] exp_fin;
    exp_cpu  = 7'b0000011;
    exp_busy = 7'b0011111;
    exp_fin  = 7'b0100000;
    @(negedge clk);
    bus.sel_mode = CMD_T;
    bus.pc_chk   = 1'b1;
    bus.start    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk($sformatf("%s clk_cpu k+%0d", tag, i + 1), 32'(bus.clk_cpu), 32'(exp_cpu[i]));
      chk($sformatf("%s busy k+%0d", tag, i + 1), 32'(bus.busy), 32'(exp_busy[i]));
      chk($sformatf("%s finish k+%0d", tag, i + 1), 32'(bus.finish), 32'(exp_fin[i]));
    end
    chk({tag, " cyc_cnt"}, bus.cyc_cnt, 32'd1);
    chk({tag, " hit"}, 32'(bus.hit), 32'd0);
  endtask

  initial begin
    logic activity;
    int   rises;
    logic prev;

    total  = 0;
    passed = 0;
    //        name           mode   bp            pc0           wrap chk stop rst pulses cyc    hit
    vecs[0] = '{"T step",     CMD_T, 32'h0000_3004, 32'h0000_3000, 0, 1'b1, 0, 0, 1, 32'd1, 1'b0};
    vecs[1] = '{"B to bp",    CMD_B, 32'h0000_3008, 32'h0000_3000, 0, 1'b1, 0, 0, 2, 32'd2, 1'b1};
    vecs[2] = '{"B start@bp", CMD_B, 32'h0000_3000, 32'h0000_3000, 4, 1'b1, 0, 0, 4, 32'd4, 1'b1};
    vecs[3] = '{"G abort",    CMD_G, 32'h0000_3000, 32'h0000_3000, 0, 1'b1, 5, 0, 5, 32'd5, 1'b0};
    vecs[4] = '{"B nochk",    CMD_B, 32'h0000_3008, 32'h0000_3000, 0, 1'b0, 5, 0, 5, 32'd5, 1'b0};
    vecs[5] = '{"B hit+stop", CMD_B, 32'h0000_3008, 32'h0000_3000, 0, 1'b1, 2, 0, 2, 32'd2, 1'b1};
    vecs[6] = '{"G restart",  CMD_G, 32'h0000_3000, 32'h0000_3000, 0, 1'b1, 4, 2, 4, 32'd4, 1'b0};

    rst          = 1'b1;
    bus.sel_mode = 8'h00;
    bus.start    = 1'b0;
    bus.bp_addr  = 32'h0;
    bus.stop_req = 1'b0;
    bus.pc_chk   = 1'b0;
    bus.pc       = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset clk_cpu", 32'(bus.clk_cpu), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset finish", 32'(bus.finish), 32'd0);
    chk("reset hit", 32'(bus.hit), 32'd0);
    chk("reset cyc_cnt", bus.cyc_cnt, 32'd0);
    rst = 1'b0;

    step_latency("T latency");

    // Illegal command code: nothing may happen, previous results held.
    @(negedge clk);
    bus.sel_mode = 8'h44;
    bus.start    = 1'b1;
    activity     = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy || bus.clk_cpu || bus.finish) activity = 1'b1;
    end
    chk("illegal start activity", 32'(activity), 32'd0);
    chk("illegal start cyc_cnt held", bus.cyc_cnt, 32'd1);

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // Asynchronous reset while clk_cpu is high during a free run.
    @(negedge clk);
    bus.sel_mode = CMD_G;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 100 && rises < 3; n++) begin
      if (bus.clk_cpu && !prev) rises++;
      prev = bus.clk_cpu;
      if (rises < 3) @(negedge clk);
    end
    chk("pre-reset third pulse", 32'(rises), 32'd3);
    chk("pre-reset clk_cpu", 32'(bus.clk_cpu), 32'd1);
    chk("pre-reset cyc_cnt", bus.cyc_cnt, 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("async rst clk_cpu", 32'(bus.clk_cpu), 32'd0);
    chk("async rst busy", 32'(bus.busy), 32'd0);
    chk("async rst cyc_cnt", bus.cyc_cnt, 32'd0);
    chk("async rst hit", 32'(bus.hit), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset idle busy", 32'(bus.busy), 32'd0);
    chk("post-reset idle clk_cpu", 32'(bus.clk_cpu), 32'd0);
    step_latency("T after reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
